// File: rtl/rob_row_bucket_pkg.sv
// Shared definitions for the row-grouping reorder buffer: FSM states,
// item field layout and item pack/unpack helpers.
package rob_pkg;

    // Default column width and the resulting item field positions
    localparam int ROB_COL_W       = 8;
    localparam int ITEM_COL_LO     = 0;
    localparam int ITEM_COL_HI     = ROB_COL_W - 1;
    localparam int ITEM_LOS_BIT    = ROB_COL_W;
    localparam int ITEM_SIZE_LO    = ROB_COL_W + 1;
    localparam int ITEM_SIZE_HI    = ROB_COL_W + 2;

    // Widest column the helpers can handle; callers cast to their own width
    localparam int ROB_COL_W_MAX   = 32;
    localparam int ROB_ITEM_W_MAX  = ROB_COL_W_MAX + 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rob_state_e;

    // Build {size, los, col} for a column field of col_w bits
    function automatic logic [ROB_ITEM_W_MAX-1:0] rob_pack(
        input logic [1:0]               size,
        input logic                     los,
        input logic [ROB_COL_W_MAX-1:0] col,
        input int unsigned              col_w
    );
        logic [ROB_ITEM_W_MAX-1:0] mask;
        mask = (ROB_ITEM_W_MAX'(1) << col_w) - ROB_ITEM_W_MAX'(1);
        return (ROB_ITEM_W_MAX'(col) & mask)
             | (ROB_ITEM_W_MAX'(los) << col_w)
             | (ROB_ITEM_W_MAX'(size) << (col_w + 1));
    endfunction

    function automatic logic [ROB_COL_W_MAX-1:0] rob_item_col(
        input logic [ROB_ITEM_W_MAX-1:0] item,
        input int unsigned               col_w
    );
        logic [ROB_ITEM_W_MAX-1:0] mask;
        mask = (ROB_ITEM_W_MAX'(1) << col_w) - ROB_ITEM_W_MAX'(1);
        return ROB_COL_W_MAX'(item & mask);
    endfunction

    function automatic logic rob_item_los(
        input logic [ROB_ITEM_W_MAX-1:0] item,
        input int unsigned               col_w
    );
        return item[col_w];
    endfunction

    function automatic logic [1:0] rob_item_size(
        input logic [ROB_ITEM_W_MAX-1:0] item,
        input int unsigned               col_w
    );
        return 2'(item >> (col_w + 1));
    endfunction

endpackage

// File: rtl/rob_row_bucket_mem.sv
// Bucket storage: NROWS*WAYS items, one write port and one read port,
// read data registered. Contents are never reset.
module rob_bucket_mem #(
    parameter int ROW_W  = 4,
    parameter int WAY_W  = 3,
    parameter int ITEM_W = 11
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ROW_W+WAY_W-1:0]  wr_addr,
    input  logic [ITEM_W-1:0]       wr_data,
    input  logic [ROW_W+WAY_W-1:0]  rd_addr,
    output logic [ITEM_W-1:0]       rd_data
);

    localparam int DEPTH = 2 ** (ROW_W + WAY_W);

    logic [ITEM_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, sampled every cycle
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rob_row_bucket.sv
// Row-grouping reorder buffer: files column requests into per-row buckets
// and drains one row oldest-first on request.
// Optional feature macro: ROB_OCC_STATS_EN adds oROB_Occupancy and oROB_Stall.
module rob_row_bucket
    import rob_pkg::*;
#(
    parameter  int ROW_W  = 4,
    parameter  int COL_W  = 8,
    parameter  int WAYS   = 8,
    parameter  int ITEM_W = COL_W + 3,
    localparam int WAY_W  = $clog2(WAYS),
    localparam int NROWS  = 2 ** ROW_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iValid,
    output logic              oReady,
    input  logic [ROW_W-1:0]  iReqRow,
    input  logic [COL_W-1:0]  iReqCol,
    input  logic [1:0]        iReqSize,
    input  logic              iLoS,
    input  logic              iROB_Rd,
    input  logic [ROW_W-1:0]  iROB_Row,
    output logic              oROB_RdReady,
    output logic              oROB_ItemValid,
    output logic [ITEM_W-1:0] oROB_Item,
    output logic              oROB_ItemEnd,
    output logic [WAY_W-1:0]  oROB_Way,
    output logic              oROB_WayWr,
    output logic              oROB_Full,
    output logic              oROB_Empty
`ifdef ROB_OCC_STATS_EN
    ,
    output logic [ROW_W+WAY_W:0] oROB_Occupancy,
    output logic                 oROB_Stall
`endif
);

    localparam logic [WAY_W:0] CNT_FULL = (WAY_W+1)'(WAYS);
    localparam logic [WAY_W:0] CNT_ONE  = (WAY_W+1)'(1);

    logic [WAY_W:0]    cnt [NROWS];
    rob_state_e        state;
    logic [ROW_W-1:0]  drain_row;
    logic [WAY_W:0]    drain_n;
    logic [WAY_W-1:0]  rd_idx;
    logic              item_valid;
    logic              item_end;
    logic [ITEM_W-1:0] rd_data;
    logic [WAY_W-1:0]  way_q;
    logic              way_wr_q;
    logic              full_q;
    logic              empty_q;

    logic [WAY_W:0]    wr_cnt;
    logic [WAY_W:0]    rd_cnt;
    logic              rd_ready;
    logic              wr_ready;
    logic              wr_acc;
    logic              rd_acc;
    logic              last_beat;
    logic              clr_en;
    logic [ROW_W-1:0]  clr_row;
    logic [ROW_W+WAY_W-1:0] mem_raddr;
    logic [ITEM_W-1:0] wr_item;
    logic              any_full;
    logic              all_empty;

    // Handshakes, drain-clear selection and read address
    always_comb begin
        wr_cnt    = cnt[iReqRow];
        rd_cnt    = cnt[iROB_Row];
        rd_ready  = (state == IDLE);
        wr_ready  = (wr_cnt != CNT_FULL)
                  & ~((state == DRAIN) & (iReqRow == drain_row))
                  & ~(rd_ready & iROB_Rd & (iROB_Row == iReqRow));
        wr_acc    = iValid & wr_ready;
        rd_acc    = iROB_Rd & rd_ready;
        last_beat = (state == DRAIN) & ({1'b0, rd_idx} == (drain_n - CNT_ONE));
        clr_en    = 1'b0;
        clr_row   = '0;
        // A single-entry drain finishes on the accept itself and never enters DRAIN
        if (rd_acc && (rd_cnt == CNT_ONE)) begin
            clr_en  = 1'b1;
            clr_row = iROB_Row;
        end else if (last_beat) begin
            clr_en  = 1'b1;
            clr_row = drain_row;
        end
        // Slot 0 is fetched in the accept cycle so the first beat leaves one cycle later
        if (state == DRAIN) begin
            mem_raddr = {drain_row, rd_idx};
        end else begin
            mem_raddr = {iROB_Row, {WAY_W{1'b0}}};
        end
        wr_item = ITEM_W'(rob_pack(iReqSize, iLoS, ROB_COL_W_MAX'(iReqCol), COL_W));
    end

    // Flag sources derived from the current counts
    always_comb begin
        any_full  = 1'b0;
        all_empty = 1'b1;
        for (int unsigned r = 0; r < NROWS; r++) begin
            if (cnt[r] == CNT_FULL) any_full = 1'b1;
            if (cnt[r] != '0)       all_empty = 1'b0;
        end
    end

    rob_bucket_mem #(
        .ROW_W  (ROW_W),
        .WAY_W  (WAY_W),
        .ITEM_W (ITEM_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr ({iReqRow, wr_cnt[WAY_W-1:0]}),
        .wr_data (wr_item),
        .rd_addr (mem_raddr),
        .rd_data (rd_data)
    );

    // Per-row occupancy counts: increment on accept, clear at end of drain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < NROWS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NROWS; r++) begin
                if (clr_en && (clr_row == ROW_W'(r))) begin
                    cnt[r] <= '0;
                end else if (wr_acc && (iReqRow == ROW_W'(r))) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end
            end
        end
    end

    // Drain FSM with registered beat valid/end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            drain_row  <= '0;
            drain_n    <= '0;
            rd_idx     <= '0;
            item_valid <= 1'b0;
            item_end   <= 1'b0;
        end else begin
            item_valid <= 1'b0;
            item_end   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_acc) begin
                        drain_row <= iROB_Row;
                        drain_n   <= rd_cnt;
                        rd_idx    <= WAY_W'(1);
                        if (rd_cnt == '0) begin
                            item_end <= 1'b1;
                        end else begin
                            item_valid <= 1'b1;
                            if (rd_cnt == CNT_ONE) begin
                                item_end <= 1'b1;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    item_valid <= 1'b1;
                    if (last_beat) begin
                        item_end <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        rd_idx <= rd_idx + WAY_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-slot report and full/empty flags, one cycle behind the counts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            way_q    <= '0;
            way_wr_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            way_wr_q <= wr_acc;
            if (wr_acc) begin
                way_q <= wr_cnt[WAY_W-1:0];
            end
            full_q  <= any_full;
            empty_q <= all_empty;
        end
    end

`ifdef ROB_OCC_STATS_EN
    logic [ROW_W+WAY_W:0] occ_sum;
    logic [ROW_W+WAY_W:0] occ_q;
    logic                 stall_q;

    // Total stored entries across all buckets
    always_comb begin
        occ_sum = '0;
        for (int unsigned r = 0; r < NROWS; r++) begin
            occ_sum = occ_sum + (ROW_W+WAY_W+1)'(cnt[r]);
        end
    end

    // Registered occupancy and sticky stall indicator
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            occ_q <= occ_sum;
            if (iValid && !wr_ready) begin
                stall_q <= 1'b1;
            end
        end
    end

    assign oROB_Occupancy = occ_q;
    assign oROB_Stall     = stall_q;
`endif

    assign oReady         = wr_ready;
    assign oROB_RdReady   = rd_ready;
    assign oROB_ItemValid = item_valid;
    assign oROB_Item      = item_valid ? rd_data : '0;
    assign oROB_ItemEnd   = item_end;
    assign oROB_Way       = way_q;
    assign oROB_WayWr     = way_wr_q;
    assign oROB_Full      = full_q;
    assign oROB_Empty     = empty_q;

endmodule

// File: tb/tb_rob_row_bucket.sv
// Directed self-checking bench for rob_row_bucket.
// Optional feature macro: ROB_OCC_STATS_EN (occupancy/stall ports).
module tb_rob_row_bucket;

    localparam int ROW_W  = 4;
    localparam int COL_W  = 8;
    localparam int WAYS   = 8;
    localparam int ITEM_W = 11;
    localparam int WAY_W  = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              iValid;
    logic              oReady;
    logic [ROW_W-1:0]  iReqRow;
    logic [COL_W-1:0]  iReqCol;
    logic [1:0]        iReqSize;
    logic              iLoS;
    logic              iROB_Rd;
    logic [ROW_W-1:0]  iROB_Row;
    logic              oROB_RdReady;
    logic              oROB_ItemValid;
    logic [ITEM_W-1:0] oROB_Item;
    logic              oROB_ItemEnd;
    logic [WAY_W-1:0]  oROB_Way;
    logic              oROB_WayWr;
    logic              oROB_Full;
    logic              oROB_Empty;
`ifdef ROB_OCC_STATS_EN
    logic [ROW_W+WAY_W:0] oROB_Occupancy;
    logic                 oROB_Stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [ITEM_W-1:0] exp_items [WAYS];

    always #5 clk = ~clk;

    rob_row_bucket #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .WAYS  (WAYS)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .iValid         (iValid),
        .oReady         (oReady),
        .iReqRow        (iReqRow),
        .iReqCol        (iReqCol),
        .iReqSize       (iReqSize),
        .iLoS           (iLoS),
        .iROB_Rd        (iROB_Rd),
        .iROB_Row       (iROB_Row),
        .oROB_RdReady   (oROB_RdReady),
        .oROB_ItemValid (oROB_ItemValid),
        .oROB_Item      (oROB_Item),
        .oROB_ItemEnd   (oROB_ItemEnd),
        .oROB_Way       (oROB_Way),
        .oROB_WayWr     (oROB_WayWr),
        .oROB_Full      (oROB_Full),
        .oROB_Empty     (oROB_Empty)
`ifdef ROB_OCC_STATS_EN
        ,
        .oROB_Occupancy (oROB_Occupancy),
        .oROB_Stall     (oROB_Stall)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single accepted write; checks ready before and slot report after
    task automatic write_req(input logic [3:0] row, input logic [7:0] col,
                             input logic [1:0] size, input logic los,
                             input logic [2:0] exp_way, input string tag);
        iValid = 1'b1; iReqRow = row; iReqCol = col; iReqSize = size; iLoS = los;
        #1;
        n_checks++;
        if (oReady !== 1'b1) begin
            n_fail++; $display("FAIL %s_ready got=%b want=1", tag, oReady);
        end
        tick;
        iValid = 1'b0;
        n_checks++;
        if (oROB_WayWr !== 1'b1 || oROB_Way !== exp_way) begin
            n_fail++; $display("FAIL %s_way got wr=%b way=%0d want wr=1 way=%0d", tag, oROB_WayWr, oROB_Way, exp_way);
        end
    endtask

    // Drain of n entries expected as exp_items[0..n-1]; returns during the last beat
    task automatic drain_req(input logic [3:0] row, input int n, input string tag);
        iROB_Rd = 1'b1; iROB_Row = row;
        #1;
        n_checks++;
        if (oROB_RdReady !== 1'b1) begin
            n_fail++; $display("FAIL %s_rdready got=%b want=1", tag, oROB_RdReady);
        end
        tick;
        iROB_Rd = 1'b0;
        if (n == 0) begin
            n_checks++;
            if (oROB_ItemEnd !== 1'b1 || oROB_ItemValid !== 1'b0 || oROB_Item !== '0) begin
                n_fail++; $display("FAIL %s_empty_end got end=%b valid=%b item=%h want end=1 valid=0 item=0", tag, oROB_ItemEnd, oROB_ItemValid, oROB_Item);
            end
        end
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (oROB_ItemValid !== 1'b1 || oROB_Item !== exp_items[k] || oROB_ItemEnd !== (k == n - 1)) begin
                n_fail++; $display("FAIL %s_beat%0d got valid=%b item=%h end=%b want valid=1 item=%h end=%b", tag, k, oROB_ItemValid, oROB_Item, oROB_ItemEnd, exp_items[k], (k == n - 1));
            end
            if (k < n - 1) tick;
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (oReady !== 1'b1 || oROB_RdReady !== 1'b1 || oROB_ItemValid !== 1'b0 || oROB_Item !== '0 ||
            oROB_ItemEnd !== 1'b0 || oROB_WayWr !== 1'b0 || oROB_Way !== '0 || oROB_Full !== 1'b0 || oROB_Empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_state got rdy=%b rdrdy=%b v=%b item=%h end=%b wr=%b way=%0d full=%b empty=%b",
                               oReady, oROB_RdReady, oROB_ItemValid, oROB_Item, oROB_ItemEnd, oROB_WayWr, oROB_Way, oROB_Full, oROB_Empty);
        end
`ifdef ROB_OCC_STATS_EN
        n_checks++;
        if (oROB_Occupancy !== '0 || oROB_Stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stats got occ=%0d stall=%b want 0 0", oROB_Occupancy, oROB_Stall);
        end
`endif
        drain_req(4'd3, 0, "empty_drain");
        tick;
        n_checks++;
        if (oROB_ItemEnd !== 1'b0 || oROB_Empty !== 1'b1) begin
            n_fail++; $display("FAIL empty_drain_after got end=%b empty=%b want end=0 empty=1", oROB_ItemEnd, oROB_Empty);
        end
    endtask

    task automatic test_in_order;
        write_req(4'd5, 8'h10, 2'd0, 1'b0, 3'd0, "order_w0");
        write_req(4'd5, 8'h20, 2'd1, 1'b1, 3'd1, "order_w1");
        write_req(4'd5, 8'h30, 2'd2, 1'b0, 3'd2, "order_w2");
        tick;
        n_checks++;
        if (oROB_Empty !== 1'b0 || oROB_Full !== 1'b0) begin
            n_fail++; $display("FAIL order_flags got empty=%b full=%b want 0 0", oROB_Empty, oROB_Full);
        end
`ifdef ROB_OCC_STATS_EN
        n_checks++;
        if (oROB_Occupancy !== 8'd3) begin
            n_fail++; $display("FAIL order_occ got=%0d want=3", oROB_Occupancy);
        end
`endif
        exp_items[0] = 11'h010; exp_items[1] = 11'h320; exp_items[2] = 11'h430;
        drain_req(4'd5, 3, "order_drain");
        tick;
        n_checks++;
        if (oROB_Empty !== 1'b1 || oROB_ItemValid !== 1'b0) begin
            n_fail++; $display("FAIL order_after got empty=%b valid=%b want 1 0", oROB_Empty, oROB_ItemValid);
        end
    endtask

    task automatic test_full;
        for (int i = 0; i < 8; i++) begin
            write_req(4'd2, 8'h80 + 8'(i), 2'd3, 1'b0, 3'(i), "full_w");
        end
        n_checks++;
        if (oROB_Full !== 1'b0) begin
            n_fail++; $display("FAIL full_lag got=%b want=0", oROB_Full);
        end
        tick;
        n_checks++;
        if (oROB_Full !== 1'b1) begin
            n_fail++; $display("FAIL full_set got=%b want=1", oROB_Full);
        end
        iValid = 1'b1; iReqRow = 4'd2; iReqCol = 8'hAA; iReqSize = 2'd0; iLoS = 1'b1;
        #1;
        n_checks++;
        if (oReady !== 1'b0) begin
            n_fail++; $display("FAIL full_stall got ready=%b want=0", oReady);
        end
        tick;
        n_checks++;
        if (oROB_WayWr !== 1'b0 || oReady !== 1'b0) begin
            n_fail++; $display("FAIL full_hold got wr=%b ready=%b want 0 0", oROB_WayWr, oReady);
        end
        for (int i = 0; i < 8; i++) exp_items[i] = 11'h680 + 11'(i);
        drain_req(4'd2, 8, "full_drain");
        #1;
        n_checks++;
        if (oReady !== 1'b1) begin
            n_fail++; $display("FAIL full_release got ready=%b want=1", oReady);
        end
        tick;
        iValid = 1'b0;
        n_checks++;
        if (oROB_WayWr !== 1'b1 || oROB_Way !== 3'd0 || oROB_Full !== 1'b0) begin
            n_fail++; $display("FAIL full_held_accept got wr=%b way=%0d full=%b want 1 0 0", oROB_WayWr, oROB_Way, oROB_Full);
        end
`ifdef ROB_OCC_STATS_EN
        n_checks++;
        if (oROB_Stall !== 1'b1) begin
            n_fail++; $display("FAIL stall_sticky got=%b want=1", oROB_Stall);
        end
`endif
        exp_items[0] = 11'h1AA;
        drain_req(4'd2, 1, "full_held_drain");
        tick;
    endtask

    task automatic test_write_during_drain;
        for (int i = 0; i < 4; i++) begin
            write_req(4'd1, 8'h41 + 8'(i), 2'd0, 1'b0, 3'(i), "wdd_w");
            exp_items[i] = 11'h041 + 11'(i);
        end
        iROB_Rd = 1'b1; iROB_Row = 4'd1;
        tick;
        iROB_Rd = 1'b0;
        iValid = 1'b1; iReqRow = 4'd7; iReqCol = 8'h77; iReqSize = 2'd0; iLoS = 1'b1;
        #1;
        n_checks++;
        if (oROB_Item !== exp_items[0] || oROB_ItemValid !== 1'b1 || oReady !== 1'b1) begin
            n_fail++; $display("FAIL wdd_b0 got item=%h v=%b ready=%b want %h 1 1", oROB_Item, oROB_ItemValid, oReady, exp_items[0]);
        end
        tick;
        iReqRow = 4'd1; iReqCol = 8'h4F; iReqSize = 2'd1; iLoS = 1'b0;
        #1;
        n_checks++;
        if (oROB_Item !== exp_items[1] || oROB_WayWr !== 1'b1 || oROB_Way !== 3'd0 || oReady !== 1'b0) begin
            n_fail++; $display("FAIL wdd_b1 got item=%h wr=%b way=%0d ready=%b want %h 1 0 0", oROB_Item, oROB_WayWr, oROB_Way, oReady, exp_items[1]);
        end
        tick;
        n_checks++;
        if (oROB_Item !== exp_items[2] || oROB_WayWr !== 1'b0 || oReady !== 1'b0 || oROB_ItemEnd !== 1'b0) begin
            n_fail++; $display("FAIL wdd_b2 got item=%h wr=%b ready=%b end=%b want %h 0 0 0", oROB_Item, oROB_WayWr, oReady, oROB_ItemEnd, exp_items[2]);
        end
        tick;
        n_checks++;
        if (oROB_Item !== exp_items[3] || oROB_ItemEnd !== 1'b1 || oReady !== 1'b1) begin
            n_fail++; $display("FAIL wdd_b3 got item=%h end=%b ready=%b want %h 1 1", oROB_Item, oROB_ItemEnd, oReady, exp_items[3]);
        end
        tick;
        iValid = 1'b0;
        n_checks++;
        if (oROB_WayWr !== 1'b1 || oROB_Way !== 3'd0 || oROB_ItemValid !== 1'b0) begin
            n_fail++; $display("FAIL wdd_late_write got wr=%b way=%0d v=%b want 1 0 0", oROB_WayWr, oROB_Way, oROB_ItemValid);
        end
        exp_items[0] = 11'h24F;
        drain_req(4'd1, 1, "wdd_row1");
        tick;
        exp_items[0] = 11'h177;
        drain_req(4'd7, 1, "wdd_row7");
        tick;
    endtask

    task automatic test_same_cycle;
        write_req(4'd4, 8'hC4, 2'd0, 1'b0, 3'd0, "same_w0");
        iROB_Rd = 1'b1; iROB_Row = 4'd4;
        iValid = 1'b1; iReqRow = 4'd4; iReqCol = 8'hD4; iReqSize = 2'd2; iLoS = 1'b0;
        #1;
        n_checks++;
        if (oReady !== 1'b0 || oROB_RdReady !== 1'b1) begin
            n_fail++; $display("FAIL same_collide got ready=%b rdready=%b want 0 1", oReady, oROB_RdReady);
        end
        tick;
        iROB_Rd = 1'b0;
        n_checks++;
        if (oROB_Item !== 11'h0C4 || oROB_ItemValid !== 1'b1 || oROB_ItemEnd !== 1'b1 || oROB_WayWr !== 1'b0) begin
            n_fail++; $display("FAIL same_beat got item=%h v=%b end=%b wr=%b want 0c4 1 1 0", oROB_Item, oROB_ItemValid, oROB_ItemEnd, oROB_WayWr);
        end
        tick;
        iValid = 1'b0;
        n_checks++;
        if (oROB_WayWr !== 1'b1 || oROB_Way !== 3'd0) begin
            n_fail++; $display("FAIL same_write got wr=%b way=%0d want 1 0", oROB_WayWr, oROB_Way);
        end
        exp_items[0] = 11'h4D4;
        drain_req(4'd4, 1, "same_drain");
        tick;
    endtask

    task automatic test_reset_mid_drain;
        write_req(4'd6, 8'h61, 2'd0, 1'b0, 3'd0, "rst_w0");
        write_req(4'd6, 8'h62, 2'd0, 1'b0, 3'd1, "rst_w1");
        write_req(4'd6, 8'h63, 2'd0, 1'b0, 3'd2, "rst_w2");
        iROB_Rd = 1'b1; iROB_Row = 4'd6;
        tick;
        iROB_Rd = 1'b0;
        tick;
        n_checks++;
        if (oROB_Item !== 11'h062 || oROB_ItemValid !== 1'b1) begin
            n_fail++; $display("FAIL rst_beat1 got item=%h v=%b want 062 1", oROB_Item, oROB_ItemValid);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if (oROB_ItemValid !== 1'b0 || oROB_Item !== '0 || oROB_ItemEnd !== 1'b0 || oROB_Empty !== 1'b1 || oROB_RdReady !== 1'b1) begin
            n_fail++; $display("FAIL rst_abort got v=%b item=%h end=%b empty=%b rdready=%b want 0 0 0 1 1", oROB_ItemValid, oROB_Item, oROB_ItemEnd, oROB_Empty, oROB_RdReady);
        end
        tick;
        resetn = 1'b1;
        tick;
        n_checks++;
        if (oROB_ItemValid !== 1'b0 || oROB_ItemEnd !== 1'b0 || oROB_Empty !== 1'b1) begin
            n_fail++; $display("FAIL rst_quiet got v=%b end=%b empty=%b want 0 0 1", oROB_ItemValid, oROB_ItemEnd, oROB_Empty);
        end
`ifdef ROB_OCC_STATS_EN
        n_checks++;
        if (oROB_Occupancy !== '0 || oROB_Stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_stats got occ=%0d stall=%b want 0 0", oROB_Occupancy, oROB_Stall);
        end
`endif
        drain_req(4'd6, 0, "rst_redrain");
        tick;
    endtask

    initial begin
        resetn = 1'b0; iValid = 1'b0; iReqRow = '0; iReqCol = '0; iReqSize = '0; iLoS = 1'b0;
        iROB_Rd = 1'b0; iROB_Row = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        tick;
        test_reset;
        test_in_order;
        test_full;
        test_write_during_drain;
        test_same_cycle;
        test_reset_mid_drain;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
